// File: rtl/cache_response_generator_if.sv
// Response-path bundle between the cache response generator and its neighbours:
// request-issue side, cache response side and per-requestor delivery side.
interface cache_response_generator_if #(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int ID_WIDTH             = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int DATA_WIDTH           = 32,
  parameter int COUNT_WIDTH          = 4
);
  logic                            req_issue_valid;
  logic [ID_WIDTH-1:0]             req_issue_id;
  logic                            id_fifo_full;
  logic                            cache_resp_valid;
  logic [DATA_WIDTH-1:0]           cache_resp_data;
  logic                            cache_resp_in_ready;
  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_valid;
  logic [DATA_WIDTH-1:0]           mem_resp_data;
  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_ready;
  logic                            resp_done;
  logic [COUNT_WIDTH-1:0]          outstanding_count;
  logic                            error_overflow;
  logic                            error_underflow;

  modport master (
    output req_issue_valid, req_issue_id, cache_resp_valid, cache_resp_data, mem_resp_ready,
    input  id_fifo_full, cache_resp_in_ready, mem_resp_valid, mem_resp_data, resp_done,
           outstanding_count, error_overflow, error_underflow
  );

  modport slave (
    input  req_issue_valid, req_issue_id, cache_resp_valid, cache_resp_data, mem_resp_ready,
    output id_fifo_full, cache_resp_in_ready, mem_resp_valid, mem_resp_data, resp_done,
           outstanding_count, error_overflow, error_underflow
  );
endinterface

// File: rtl/cache_response_generator.sv
// In-order cache response router: pairs each response with the oldest queued requestor ID.
// Response at cycle N is offered at N+2 and held until that requestor's ready; upstream throttled by id_fifo_full / cache_resp_in_ready.

// Generic FIFO with combinational head and occupancy count; caller never pushes when full.
module cache_response_generator_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   ap_clk,
  input  logic                   areset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [COUNT_WIDTH-1:0] count
);
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module cache_response_generator #(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int ID_WIDTH             = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int DATA_WIDTH           = 32,
  parameter int FIFO_DEPTH           = 8,
  parameter int COUNT_WIDTH          = $clog2(FIFO_DEPTH + 1)
) (
  input logic                       ap_clk,
  input logic                       areset,
  cache_response_generator_if.slave bus
);
  typedef enum logic [1:0] {RESP_RESET, RESP_IDLE, RESP_SEND, RESP_DONE} resp_state_t;

  localparam logic [COUNT_WIDTH-1:0] DEPTH_FULL = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_M1   = COUNT_WIDTH'(FIFO_DEPTH - 1);

  resp_state_t                     state, state_nxt;
  logic [COUNT_WIDTH-1:0]          id_count, dat_count;
  logic [ID_WIDTH-1:0]             id_head, held_id;
  logic [DATA_WIDTH-1:0]           dat_head, held_dat;
  logic                            id_full_q, in_rdy_q, err_ovf_q, err_udf_q;
  logic                            id_push, dat_push, pop, hs, id_invalid;
  logic [NUM_MEMORY_REQUESTOR-1:0] held_onehot;

  assign id_push     = bus.req_issue_valid && !id_full_q;
  assign dat_push    = bus.cache_resp_valid && in_rdy_q;
  assign pop         = (state == RESP_IDLE || state == RESP_DONE) && id_count != '0 && dat_count != '0;
  assign held_onehot = NUM_MEMORY_REQUESTOR'(1) << held_id;
  assign hs          = (state == RESP_SEND) && !id_invalid && ((bus.mem_resp_ready & held_onehot) != '0);

  // An out-of-range ID can only exist when the requestor count is not a power of two.
  if ((1 << ID_WIDTH) != NUM_MEMORY_REQUESTOR) begin : g_id_check
    localparam logic [ID_WIDTH:0] NUM_REQ = (ID_WIDTH + 1)'(NUM_MEMORY_REQUESTOR);
    assign id_invalid = ({1'b0, held_id} >= NUM_REQ);
  end else begin : g_id_ok
    assign id_invalid = 1'b0;
  end

  cache_response_generator_fifo #(.WIDTH(ID_WIDTH), .DEPTH(FIFO_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) u_id_fifo (
    .ap_clk(ap_clk), .areset(areset), .push(id_push), .push_dat(bus.req_issue_id),
    .pop(pop), .head_dat(id_head), .count(id_count)
  );

  cache_response_generator_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) u_dat_fifo (
    .ap_clk(ap_clk), .areset(areset), .push(dat_push), .push_dat(bus.cache_resp_data),
    .pop(pop), .head_dat(dat_head), .count(dat_count)
  );

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      id_full_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      id_full_q <= (id_count == DEPTH_FULL && !pop) || (id_count == DEPTH_M1 && id_push && !pop);
      // Ready ignores a same-cycle pop, so it can never admit a push into a full FIFO.
      in_rdy_q  <= (dat_count < DEPTH_M1) || (dat_count == DEPTH_M1 && !dat_push);
      if ((bus.req_issue_valid && id_full_q) || (state == RESP_SEND && id_invalid)) err_ovf_q <= 1'b1;
      if (dat_push && id_count == '0 && !id_push) err_udf_q <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      held_id  <= '0;
      held_dat <= '0;
    end else if (pop) begin
      held_id  <= id_head;
      held_dat <= dat_head;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) state <= RESP_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESP_RESET: state_nxt = RESP_IDLE;
      RESP_IDLE:  if (pop) state_nxt = RESP_SEND;
      RESP_SEND:  if (hs || id_invalid) state_nxt = RESP_DONE;
      RESP_DONE:  state_nxt = pop ? RESP_SEND : RESP_IDLE;
      default:    state_nxt = RESP_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp_valid = '0;
    bus.mem_resp_data  = '0;
    bus.resp_done      = 1'b0;
    if (state == RESP_SEND && !id_invalid) begin
      bus.mem_resp_valid = held_onehot;
      bus.mem_resp_data  = held_dat;
    end
    if (state == RESP_DONE) bus.resp_done = 1'b1;
  end

  assign bus.id_fifo_full        = id_full_q;
  assign bus.cache_resp_in_ready = in_rdy_q;
  assign bus.outstanding_count   = id_count;
  assign bus.error_overflow      = err_ovf_q;
  assign bus.error_underflow     = err_udf_q;
endmodule

// File: tb/tb_cache_response_generator.sv
// Directed scenarios plus randomized traffic checked against a queue-based pairing model.
module tb_cache_response_generator;
  localparam int NUM = 2;
  localparam int IDW = 1;
  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int CW  = 4;

  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  always #5 ap_clk = ~ap_clk;

  cache_response_generator_if #(.NUM_MEMORY_REQUESTOR(NUM), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  cache_response_generator #(
    .NUM_MEMORY_REQUESTOR(NUM), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .COUNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int dlv_cnt  = 0;
  int n_issued = 0;
  int n_resp   = 0;
  logic [IDW-1:0] id_q[$];
  logic [DW-1:0]  dat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven: scores this cycle, then advances one clock.
  task automatic step();
    logic hs;
    int   idx;
    if (!areset) begin
      if (bus.resp_done) done_cnt++;
      if (bus.mem_resp_valid != '0) check_eq("onehot", $countones(bus.mem_resp_valid), 1);
      hs = (bus.mem_resp_valid & bus.mem_resp_ready) != '0;
      if (hs) begin
        idx = 0;
        for (int i = 0; i < NUM; i++) if (bus.mem_resp_valid[i]) idx = i;
        dlv_cnt++;
        check_eq("dlv_pending", (id_q.size() > 0 && dat_q.size() > 0), 1);
        if (id_q.size() > 0 && dat_q.size() > 0) begin
          check_eq("dlv_id", idx, id_q.pop_front());
          check_eq("dlv_dat", bus.mem_resp_data, dat_q.pop_front());
        end
      end
      if (bus.req_issue_valid && !bus.id_fifo_full) begin
        id_q.push_back(bus.req_issue_id);
        n_issued++;
      end
      if (bus.cache_resp_valid && bus.cache_resp_in_ready) begin
        dat_q.push_back(bus.cache_resp_data);
        n_resp++;
      end
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic clear_model();
    id_q.delete();
    dat_q.delete();
    n_issued = 0;
    n_resp   = 0;
  endtask

  task automatic apply_reset();
    areset               = 1'b1;
    bus.req_issue_valid  = 1'b0;
    bus.cache_resp_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge ap_clk);
    areset = 1'b0;
    step();
  endtask

  task automatic issue(input logic [IDW-1:0] id);
    bus.req_issue_valid = 1'b1;
    bus.req_issue_id    = id;
    step();
    bus.req_issue_valid = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] d);
    bus.cache_resp_valid = 1'b1;
    bus.cache_resp_data  = d;
    step();
    bus.cache_resp_valid = 1'b0;
  endtask

  initial begin
    int k, d0, l0;
    logic [DW-1:0] a_dat;
    bus.req_issue_valid  = 1'b0;
    bus.req_issue_id     = '0;
    bus.cache_resp_valid = 1'b0;
    bus.cache_resp_data  = '0;
    bus.mem_resp_ready   = '0;

    // Reset then idle
    repeat (2) @(negedge ap_clk);
    check_eq("rst_vld", bus.mem_resp_valid, 0);
    check_eq("rst_dat", bus.mem_resp_data, 0);
    check_eq("rst_done", bus.resp_done, 0);
    check_eq("rst_full", bus.id_fifo_full, 0);
    check_eq("rst_rdy", bus.cache_resp_in_ready, 0);
    check_eq("rst_cnt", bus.outstanding_count, 0);
    check_eq("rst_ovf", bus.error_overflow, 0);
    check_eq("rst_udf", bus.error_underflow, 0);
    areset = 1'b0;
    step();
    check_eq("rel_rdy", bus.cache_resp_in_ready, 1);
    check_eq("rel_full", bus.id_fifo_full, 0);
    check_eq("rel_cnt", bus.outstanding_count, 0);

    // Single response with latency N+2
    bus.mem_resp_ready = 2'b11;
    issue(1'b1);
    step();
    respond(32'hDEADBEEF);
    check_eq("t2_n1_vld", bus.mem_resp_valid, 0);
    check_eq("t2_n1_cnt", bus.outstanding_count, 1);
    step();
    check_eq("t2_vld", bus.mem_resp_valid, 2'b10);
    check_eq("t2_dat", bus.mem_resp_data, 32'hDEADBEEF);
    d0 = done_cnt;
    step();
    check_eq("t2_done", bus.resp_done, 1);
    repeat (3) step();
    check_eq("t2_done_cnt", done_cnt - d0, 1);
    check_eq("t2_cnt", bus.outstanding_count, 0);

    // Four responses, requestor 0 stalled, then in-order drain
    bus.mem_resp_ready = 2'b10;
    issue(1'b0); issue(1'b1); issue(1'b0); issue(1'b1);
    a_dat = $urandom;
    respond(a_dat);
    for (int i = 0; i < 3; i++) respond($urandom);
    k = 0;
    while (bus.mem_resp_valid == '0 && k < 10) begin step(); k++; end
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_vld", bus.mem_resp_valid, 2'b01);
      check_eq("t3_hold_dat", bus.mem_resp_data, a_dat);
      step();
    end
    bus.mem_resp_ready = 2'b11;
    d0 = done_cnt;
    l0 = dlv_cnt;
    k  = 0;
    while (dlv_cnt - l0 < 4 && k < 30) begin step(); k++; end
    check_eq("t3_thruput", k, 7);
    repeat (2) step();
    check_eq("t3_dlv", dlv_cnt - l0, 4);
    check_eq("t3_done_cnt", done_cnt - d0, 4);

    // ID FIFO fill and overflow
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      issue(IDW'($urandom_range(1, 0)));
      if (i == 6) check_eq("t4_full7", bus.id_fifo_full, 0);
      if (i == 7) begin
        check_eq("t4_full8", bus.id_fifo_full, 1);
        check_eq("t4_ovf8", bus.error_overflow, 0);
      end
    end
    check_eq("t4_ovf", bus.error_overflow, 1);
    check_eq("t4_cnt", bus.outstanding_count, 8);
    check_eq("t4_full", bus.id_fifo_full, 1);

    // Underflow: data ahead of its ID
    apply_reset();
    respond($urandom);
    check_eq("t5_udf", bus.error_underflow, 1);
    check_eq("t5_ovf", bus.error_overflow, 0);
    repeat (3) step();
    check_eq("t5_no_vld", bus.mem_resp_valid, 0);
    l0 = dlv_cnt;
    issue(1'b0);
    k = 0;
    while (dlv_cnt == l0 && k < 10) begin step(); k++; end
    check_eq("t5_dlv", dlv_cnt - l0, 1);
    check_eq("t5_udf_sticky", bus.error_underflow, 1);

    // Reset in the middle of a send
    apply_reset();
    bus.mem_resp_ready = 2'b00;
    issue(1'b0); issue(1'b1); issue(1'b1); issue(1'b0);
    for (int i = 0; i < 4; i++) respond($urandom);
    k = 0;
    while (bus.mem_resp_valid == '0 && k < 10) begin step(); k++; end
    check_eq("t6_in_send", bus.mem_resp_valid, 2'b01);
    areset = 1'b1;
    #1;
    check_eq("t6_rst_vld", bus.mem_resp_valid, 0);
    check_eq("t6_rst_cnt", bus.outstanding_count, 0);
    clear_model();
    repeat (2) @(negedge ap_clk);
    areset = 1'b0;
    bus.mem_resp_ready = 2'b11;
    l0 = dlv_cnt;
    repeat (8) step();
    check_eq("t6_cnt", bus.outstanding_count, 0);
    check_eq("t6_ovf", bus.error_overflow, 0);
    check_eq("t6_udf", bus.error_underflow, 0);
    check_eq("t6_stale", dlv_cnt - l0, 0);

    // Randomized traffic under flow control
    apply_reset();
    l0 = dlv_cnt;
    for (int c = 0; c < 3000; c++) begin
      bus.req_issue_valid  = ($urandom_range(1, 0) == 1) && !bus.id_fifo_full;
      bus.req_issue_id     = IDW'($urandom_range(1, 0));
      bus.cache_resp_valid = (n_issued > n_resp) && ($urandom_range(1, 0) == 1);
      bus.cache_resp_data  = $urandom;
      bus.mem_resp_ready   = ($urandom_range(3, 0) == 0) ? 2'b00 : NUM'($urandom_range(3, 0));
      step();
    end
    bus.req_issue_valid  = 1'b0;
    bus.cache_resp_valid = 1'b0;
    bus.mem_resp_ready   = 2'b11;
    k = 0;
    while ((id_q.size() > 0 || dat_q.size() > 0) && k < 200) begin step(); k++; end
    repeat (3) step();
    check_eq("rnd_id_left", id_q.size(), 0);
    check_eq("rnd_dat_left", dat_q.size(), 0);
    check_eq("rnd_cnt", bus.outstanding_count, 0);
    check_eq("rnd_ovf", bus.error_overflow, 0);
    check_eq("rnd_udf", bus.error_underflow, 0);
    check_eq("rnd_dlv_seen", (dlv_cnt - l0) > 100, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
